// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side logic: FSM state encoding and a
// constant-safe ceiling-log2 helper for sizing index and counter fields.
package fifo_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first set request found scanning
// upward from i_last_idx+1, wrapping through NUM_REQ-1 back to i_last_idx.
module rr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IdxW    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IdxW-1:0]    i_last_idx,
  output logic               o_any,
  output logic [IdxW-1:0]    o_idx
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [2*NUM_REQ-1:0] w_mask;

  assign w_dbl = {i_req, i_req};
  assign o_any = |i_req;

  // Bits at or below the last winner are masked; the upper copy supplies the wrap.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      w_mask[i] = (i > int'(i_last_idx)) && w_dbl[i];
    end
  end

  always_comb begin
    o_idx = '0;
    for (int i = 2 * NUM_REQ - 1; i >= 0; i--) begin
      if (w_mask[i]) o_idx = IdxW'(i % NUM_REQ);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async FIFO write port among NUM_REQ requesters: round-robin pick in
// IDLE, then the owner holds the port until its last beat or MAX_BURST beats.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned IdxW       = clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_REQ-1:0]            i_last,
  input  logic                          i_full,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_wr_en,
  output logic [DATA_WIDTH-1:0]         o_wr_data,
  output logic [IdxW-1:0]               o_owner,
  output logic                          o_busy
);

  localparam int unsigned CntW = clog2(MAX_BURST) + 1;

  state_e            r_state,    w_state_nxt;
  logic [IdxW-1:0]   r_owner,    w_owner_nxt;
  logic [IdxW-1:0]   r_rr_last,  w_rr_last_nxt;
  logic [CntW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic              w_any;
  logic [IdxW-1:0]   w_pick;
  logic              w_beat;
  logic              w_release;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IdxW    (IdxW)
  ) u_rr_arbiter (
    .i_req      (i_req),
    .i_last_idx (r_rr_last),
    .o_any      (w_any),
    .o_idx      (w_pick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_last  <= IdxW'(NUM_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_last  <= w_rr_last_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_last_nxt  = r_rr_last;
    w_beat_cnt_nxt = r_beat_cnt;
    w_beat         = 1'b0;
    w_release      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt    = ST_LOCK;
          w_owner_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      ST_LOCK: begin
        w_beat = i_req[r_owner] & ~i_full;
        // Release only on an accepted beat so a stalled last beat is never dropped.
        w_release = w_beat &
                    (i_last[r_owner] | (r_beat_cnt == CntW'(MAX_BURST - 1)));
        if (w_beat) w_beat_cnt_nxt = r_beat_cnt + 1'b1;
        if (w_release) begin
          w_state_nxt   = ST_IDLE;
          w_rr_last_nxt = r_owner;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_owner == IdxW'(k)) o_wr_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_wr_en = w_beat;
  assign o_gnt   = w_beat ? (NUM_REQ'(1) << r_owner) : '0;
  assign o_owner = r_owner;
  assign o_busy  = (r_state == ST_LOCK);

endmodule
